// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bus of the sprite ROM arbiter: read requests in, grants and
// returned pixels out, with every requester's lanes packed side by side.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 12
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;

  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one sprite ROM between the player blobs and
// the grid layer, routes each returned word back to its issuer, and counts contention.
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 5,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 12,
  parameter int ROM_LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_start,
  sprite_rom_arbiter_if.slave  req_bus,
  output logic                 rom_en,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [DATA_W-1:0]    rom_data,
  output logic [15:0]          conflict_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t               LAST_IDX = idx_t'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] REQ_ONE  = NUM_REQ'(1);

  idx_t               last_grant;
  idx_t               grant_idx;
  idx_t               cand;
  logic               grant_valid;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               handshake;

  // Search begins just after the last winner and wraps, so nobody waits
  // more than NUM_REQ-1 grants while it stays valid.
  always_comb begin
    // NOTE: every variable gets a default before the loop; a path that left one
    // unassigned would make synthesis infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = idx_t'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_valid && req_bus.req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_onehot      = grant_valid ? (REQ_ONE << grant_idx) : '0;
  assign req_bus.req_ready = reset ? grant_onehot : '0;
  assign handshake         = |req_bus.req_ready;

  // Issue stage: the registered address plus the tag of the requester behind it.
  idx_t issue_tag;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= LAST_IDX;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      issue_tag  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // sees the values from before this edge, independent of statement order.
      if (frame_start) begin
        last_grant <= LAST_IDX;
      end else if (handshake) begin
        last_grant <= grant_idx;
      end
      rom_en    <= handshake;
      issue_tag <= grant_idx;
      if (handshake) begin
        rom_addr <= req_bus.req_addr[grant_idx];
      end
    end
  end

  // Tag pipeline tracks the ROM's own latency; its last stage lines up with rom_data.
  logic [ROM_LATENCY-1:0] tag_valid;
  idx_t                   tag_idx [ROM_LATENCY];
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic [DATA_W-1:0]      rsp_data_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the tag valids must clear so in-flight reads are dropped; the
      // indices are only a few bits and are cleared with them.
      tag_valid   <= '0;
      for (int s = 0; s < ROM_LATENCY; s++) begin
        tag_idx[s] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      tag_valid[0] <= rom_en;
      tag_idx[0]   <= issue_tag;
      for (int s = 1; s < ROM_LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_idx[s]   <= tag_idx[s-1];
      end
      if (tag_valid[ROM_LATENCY-1]) begin
        rsp_valid_q <= REQ_ONE << tag_idx[ROM_LATENCY-1];
        rsp_data_q  <= rom_data;
      end else begin
        rsp_valid_q <= '0;
      end
    end
  end

  assign req_bus.rsp_valid = rsp_valid_q;
  assign req_bus.rsp_data  = rsp_data_q;

  // Contention: cycles with two or more requesters competing, saturating.
  logic [15:0] conflict_cnt;
  logic [15:0] cnt_next;
  logic        multi_req;

  assign multi_req = $countones(req_bus.req_valid) >= 2;
  assign cnt_next  = (multi_req && conflict_cnt != 16'hFFFF) ? conflict_cnt + 16'd1
                                                             : conflict_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conflict_cnt   <= '0;
      conflict_count <= '0;
    end else if (frame_start) begin
      conflict_count <= cnt_next;
      conflict_cnt   <= '0;
    end else begin
      conflict_cnt   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed vector table, reset and saturation
// sequences, and random traffic against a transaction-level reference model.
module tb_sprite_rom_arbiter;

  localparam int NUM_REQ = 5;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 12;
  localparam int ROM_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [15:0]       conflict_count;

  sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LATENCY(ROM_LAT)
  ) dut (
    .clock          (clk),
    .reset          (rst_n),
    .frame_start    (frame_start),
    .req_bus        (bus),
    .rom_en         (rom_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .conflict_count (conflict_count)
  );

  always #5 clk = ~clk;

  // Sprite ROM: word = low 12 address bits, ROM_LAT cycles after the address.
  logic [ADDR_W-1:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_addr;
    for (int s = 1; s < ROM_LAT; s++) rom_pipe[s] <= rom_pipe[s-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1][DATA_W-1:0];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a pointer, a queue of expected responses, plain counters.
  typedef struct {
    int                due;
    int                idx;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t              exp_q[$];
  int                m_last;
  int                m_cnt;
  int                m_cc;
  logic              m_rom_en;
  logic [ADDR_W-1:0] m_rom_addr;
  logic [DATA_W-1:0] m_rsp_d;
  logic [31:0]       m_rsp_v;
  logic [NUM_REQ-1:0] seen_ready;
  int                last_g;

  task automatic model_reset();
    exp_q.delete();
    m_last = NUM_REQ - 1;
    m_cnt = 0;  m_cc = 0;
    m_rom_en = 1'b0;  m_rom_addr = '0;
    m_rsp_d = '0;  m_rsp_v = '0;
  endtask

  // One clock: drive inputs at posedge+1, check the grant, step, check outputs.
  task automatic tick(input logic [NUM_REQ-1:0] v, input logic fs, input bit chk);
    int   g;
    rsp_t r;
    bus.req_valid = v;
    frame_start   = fs;
    #1;
    g = -1;
    for (int k = 1; k <= NUM_REQ; k++)
      if (g < 0 && v[(m_last + k) % NUM_REQ]) g = (m_last + k) % NUM_REQ;
    seen_ready = bus.req_ready;
    if (chk) check("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    m_rom_en = (g >= 0);
    if (g >= 0) begin
      r.due  = cyc + ROM_LAT + 2;
      r.idx  = g;
      r.data = bus.req_addr[g][DATA_W-1:0];
      exp_q.push_back(r);
      m_rom_addr = bus.req_addr[g];
    end
    if ($countones(v) >= 2 && m_cnt < 65535) m_cnt++;
    if (fs) begin
      m_cc   = m_cnt;
      m_cnt  = 0;
      m_last = NUM_REQ - 1;
    end else if (g >= 0) begin
      m_last = g;
    end
    last_g = g;
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) bus.req_addr[g] = ADDR_W'($urandom);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      m_rsp_v = 32'd1 << r.idx;
      m_rsp_d = r.data;
    end else begin
      m_rsp_v = '0;
    end
    if (chk) begin
      check("rom_en", 32'(rom_en), 32'(m_rom_en));
      check("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
      check("conflict_count", 32'(conflict_count), 32'(m_cc));
      check("rsp_valid", 32'(bus.rsp_valid), m_rsp_v);
      check("rsp_data", 32'(bus.rsp_data), 32'(m_rsp_d));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_rom_en"}, 32'(rom_en), 32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    check({tag, "_conflict"}, 32'(conflict_count), 32'd0);
  endtask

  typedef struct {
    logic [NUM_REQ-1:0] v;
    logic               fs;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] rsp;
    int                 cc;
  } vec_t;

  vec_t               tbl [36];
  logic [NUM_REQ-1:0] pend;

  initial begin
    // Reset release with requester 2, then all five, frame_start overrides, sparse.
    tbl[0]  = '{5'b00100, 1'b0, 5'b00100, 5'b00000, 0};
    tbl[1]  = '{5'b00000, 1'b0, 5'b00000, 5'b00000, 0};
    tbl[2]  = '{5'b00000, 1'b0, 5'b00000, 5'b00000, 0};
    tbl[3]  = '{5'b00000, 1'b0, 5'b00000, 5'b00100, 0};
    tbl[4]  = '{5'b00000, 1'b1, 5'b00000, 5'b00000, 0};
    tbl[5]  = '{5'b11111, 1'b0, 5'b00001, 5'b00000, 0};
    tbl[6]  = '{5'b11111, 1'b0, 5'b00010, 5'b00000, 0};
    tbl[7]  = '{5'b11111, 1'b0, 5'b00100, 5'b00000, 0};
    tbl[8]  = '{5'b11111, 1'b0, 5'b01000, 5'b00001, 0};
    tbl[9]  = '{5'b11111, 1'b0, 5'b10000, 5'b00010, 0};
    tbl[10] = '{5'b11111, 1'b0, 5'b00001, 5'b00100, 0};
    tbl[11] = '{5'b11111, 1'b0, 5'b00010, 5'b01000, 0};
    tbl[12] = '{5'b11111, 1'b0, 5'b00100, 5'b10000, 0};
    tbl[13] = '{5'b11111, 1'b0, 5'b01000, 5'b00001, 0};
    tbl[14] = '{5'b11111, 1'b0, 5'b10000, 5'b00010, 0};
    tbl[15] = '{5'b00000, 1'b1, 5'b00000, 5'b00100, 10};
    tbl[16] = '{5'b00000, 1'b0, 5'b00000, 5'b01000, 10};
    tbl[17] = '{5'b00000, 1'b0, 5'b00000, 5'b10000, 10};
    tbl[18] = '{5'b00000, 1'b0, 5'b00000, 5'b00000, 10};
    tbl[19] = '{5'b01010, 1'b0, 5'b00010, 5'b00000, 10};
    tbl[20] = '{5'b01010, 1'b1, 5'b01000, 5'b00000, 2};
    tbl[21] = '{5'b01010, 1'b1, 5'b00010, 5'b00000, 1};
    tbl[22] = '{5'b01010, 1'b0, 5'b00010, 5'b00010, 1};
    tbl[23] = '{5'b00000, 1'b0, 5'b00000, 5'b01000, 1};
    tbl[24] = '{5'b00000, 1'b0, 5'b00000, 5'b00010, 1};
    tbl[25] = '{5'b00000, 1'b0, 5'b00000, 5'b00010, 1};
    for (int i = 0; i < 3; i++) begin
      tbl[26 + 3*i] = '{5'b10000, 1'b0, 5'b10000, (i == 0) ? 5'b00000 : 5'b10000, 1};
      tbl[27 + 3*i] = '{5'b00000, 1'b0, 5'b00000, 5'b00000, 1};
      tbl[28 + 3*i] = '{5'b00000, 1'b0, 5'b00000, 5'b00000, 1};
    end
    tbl[35] = '{5'b00000, 1'b0, 5'b00000, 5'b10000, 1};

    rst_n = 1'b0;
    frame_start = 1'b0;
    bus.req_valid = 5'b00100;
    for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i] = ADDR_W'($urandom);
    bus.req_addr[2] = 14'h0123;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 36; i++) begin
      tick(tbl[i].v, tbl[i].fs, 1'b1);
      check("tbl_ready", 32'(seen_ready), 32'(tbl[i].ready));
      check("tbl_rsp_valid", 32'(bus.rsp_valid), 32'(tbl[i].rsp));
      check("tbl_conflict", 32'(conflict_count), 32'(tbl[i].cc));
      if (i == 3) check("first_rsp_data", 32'(bus.rsp_data), 32'h123);
    end

    // Two reads in flight when reset hits: outputs clear at once, nothing returns.
    tick(5'b00011, 1'b0, 1'b1);
    tick(5'b00011, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midflight_reset");
    bus.req_valid = '0;
    frame_start = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick('0, 1'b0, 1'b1);
      check("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Random protocol-respecting traffic with occasional frame starts.
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend[i] && $urandom_range(0, 99) < 40) pend[i] = 1'b1;
      tick(pend, ($urandom_range(0, 39) == 0), 1'b1);
      if (last_g >= 0) pend[last_g] = 1'b0;
    end
    for (int i = 0; i < 6; i++) tick('0, 1'b0, 1'b1);

    // Saturation: contention on every cycle for longer than 16 bits can count.
    tick('0, 1'b1, 1'b1);
    for (int n = 0; n < 70000; n++) tick(5'b00011, 1'b0, 1'b0);
    tick(5'b00011, 1'b1, 1'b1);
    check("saturated_conflict", 32'(conflict_count), 32'h0000_FFFF);
    for (int n = 0; n < 3; n++) tick(5'b00110, 1'b0, 1'b1);
    tick('0, 1'b1, 1'b1);
    check("restarted_conflict", 32'(conflict_count), 32'd3);
    for (int i = 0; i < 6; i++) tick('0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
